// File: rtl/xmint_pkg.sv
// xmint_pkg: shared defaults, lock state type and pointer helper for the xmint arbiter mux
package xmint_pkg;
  localparam int DefN = 4;
  localparam int DefDataWidth = 8;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction
endpackage

// File: rtl/xmint_arb_mux_if.sv
// xmint_arb_mux_if: N-channel valid/ready/last/data inputs and the single muxed output beat
interface xmint_arb_mux_if import xmint_pkg::*; #(
  parameter int N = DefN,
  parameter int MuxDataWidth = DefDataWidth
);
  localparam int SelWidth = $clog2(N);
  logic [N-1:0] valid_i;
  logic [N-1:0] ready_o;
  logic [N-1:0] last_i;
  logic [N*MuxDataWidth-1:0] data_i;
  logic valid_o;
  logic ready_i;
  logic last_o;
  logic [MuxDataWidth-1:0] data_o;
  logic [SelWidth-1:0] sel_o;
  modport slave(input valid_i, data_i, last_i, ready_i, output ready_o, valid_o, data_o, last_o, sel_o);
  modport master(output valid_i, data_i, last_i, ready_i, input ready_o, valid_o, data_o, last_o, sel_o);
endinterface

// File: rtl/xmint_rr_arbiter.sv
// xmint_rr_arbiter: first requesting channel at or above ptr, wrapping modulo N
module xmint_rr_arbiter import xmint_pkg::*; #(
  parameter int N = DefN,
  localparam int SelWidth = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [SelWidth-1:0] ptr,
  output logic [SelWidth-1:0] gnt,
  output logic                gnt_valid
);
  // scan from the farthest offset down so the nearest request is written last
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = SelWidth'((int'(ptr) + i) % N);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xmint_arb_mux.sv
// xmint_arb_mux: packet-locked round-robin N:1 mux with a single registered output stage
module xmint_arb_mux import xmint_pkg::*; #(
  parameter int N = DefN,
  parameter int MuxDataWidth = DefDataWidth
) (
  input logic clk_i,
  input logic rst_ni,
  xmint_arb_mux_if.slave bus
);
  localparam int SelWidth = $clog2(N);
  lock_e state, state_nxt;
  logic [SelWidth-1:0] rr_ptr, arb_gnt, grant;
  logic arb_valid, grant_valid, can_load, xfer, last_sel;
  xmint_rr_arbiter #(.N(N)) u_arb (
    .req(bus.valid_i),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .gnt_valid(arb_valid)
  );
  // sel_o keeps the last transferred channel, so it doubles as the lock owner
  always_comb begin
    can_load = !bus.valid_o || bus.ready_i;
    grant = (state == LOCKED) ? bus.sel_o : arb_gnt;
    grant_valid = (state == LOCKED) ? bus.valid_i[bus.sel_o] : arb_valid;
    xfer = rst_ni && can_load && grant_valid;
    bus.ready_o = xfer ? N'(1) << grant : '0;
    last_sel = bus.last_i[grant];
    state_nxt = xfer ? (last_sel ? UNLOCKED : LOCKED) : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= UNLOCKED;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.valid_o <= 1'b0;
      bus.data_o <= '0;
      bus.last_o <= 1'b0;
      bus.sel_o <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      bus.valid_o <= 1'b1;
      bus.data_o <= bus.data_i[int'(grant) * MuxDataWidth +: MuxDataWidth];
      bus.last_o <= last_sel;
      bus.sel_o <= grant;
      if (last_sel) rr_ptr <= SelWidth'(wrap_inc(int'(grant), N));
    end else if (can_load) begin
      bus.valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/xmint_arb_mux.md
XMINT_ARB_MUX -- requirements
Module: xmint_arb_mux

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of input channels; legal range 2..16.
REQ-002 The block SHALL have parameter MuxDataWidth, default 8, meaning data width per channel in bits.
REQ-003 The block SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port valid_i  input  N  per-channel request; bit k belongs to channel k.
REQ-006 The block SHALL have port ready_o  output  N  per-channel accept.
REQ-007 The block SHALL have port data_i  input  N*MuxDataWidth  packed data; channel k occupies bits [k*MuxDataWidth +: MuxDataWidth].
REQ-008 The block SHALL have port last_i  input  N  per-channel end-of-packet marker.
REQ-009 The block SHALL have port valid_o  output  1  output beat valid.
REQ-010 The block SHALL have port ready_i  input  1  downstream accept.
REQ-011 The block SHALL have port data_o  output  MuxDataWidth  selected data.
REQ-012 The block SHALL have port last_o  output  1  end-of-packet of the output beat.
REQ-013 The block SHALL have port sel_o  output  $clog2(N)  source channel index of the output beat.

Function
REQ-014 The block SHALL hold valid_o, data_o, last_o and sel_o in one output register stage; input-to-output latency is exactly 1 cycle.
REQ-015 The output register SHALL load when can_load = !valid_o || ready_i; otherwise it holds, with all outputs stable.
REQ-016 While unlocked, grant SHALL be the first channel with valid_i set, searching from rr_ptr upward modulo N (N-1 wraps to 0).
REQ-017 While locked, grant SHALL be the locked channel only, regardless of other valid_i bits.
REQ-018 ready_o[k] SHALL be can_load && grant==k && valid_i[k]; all other ready_o bits are 0; ready_o is combinational with no dependency on ready_o itself.
REQ-019 An input beat SHALL transfer on a cycle with valid_i[g] && ready_o[g]; the register then loads data_i[g], last_i[g], sel_o=g and valid_o=1.
REQ-020 A transfer with last_i[g]=0 SHALL set lock on channel g.
REQ-021 A transfer with last_i[g]=1 SHALL clear lock and set rr_ptr = (g+1) mod N.
REQ-022 When can_load holds and no beat transfers, valid_o SHALL clear to 0 on the next edge; data_o, last_o and sel_o are don't-care but SHALL hold their previous values.
REQ-023 If the locked channel drops valid_i mid-packet, lock SHALL persist and no other channel SHALL be granted.
REQ-024 Sustained throughput SHALL be one beat per cycle when ready_i stays 1, including back-to-back packets from different channels.
REQ-025 Simultaneous output drain and input load in one cycle SHALL replace the register contents without a bubble.

Reset
REQ-026 While rst_ni=0, valid_o, data_o, last_o, sel_o, lock and rr_ptr SHALL be 0 asynchronously; ready_o SHALL be 0.
REQ-027 Reset mid-packet SHALL discard lock and the in-flight beat; after release, arbitration restarts from channel 0.

Structure
REQ-028 The block SHALL use a localparam SelWidth = $clog2(N); default width constants SHALL live in the shared package xmint_pkg.
REQ-029 Round-robin grant selection SHALL be a separate combinational sub-module xmint_rr_arbiter (inputs request vector and pointer, output grant index and grant-valid).

Verification (N=4, MuxDataWidth=8)
REQ-030 The bench SHALL drive valid_i=4'b1111 with single-beat packets (last_i=4'b1111), data AA,BB,CC,DD on ch0..3 and ready_i=1, and SHALL require sel_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 The bench SHALL send a 3-beat packet on ch2 (11,22,33, last on 33) with ch0 also valid, and SHALL require all three ch2 beats contiguous before any ch0 beat, followed by sel_o=0.
REQ-032 The bench SHALL hold ready_i=0 for 5 cycles with valid_o=1, data_o=5A, and SHALL require data_o, sel_o and last_o unchanged and ready_o=0 throughout, then one transfer on the cycle ready_i returns to 1.
REQ-033 The bench SHALL drop valid_i on ch1 mid-packet while ch3 is valid, and SHALL require ready_o[3]=0 until ch1 delivers its last beat.
REQ-034 The bench SHALL assert rst_ni=0 mid-packet between clock edges, and SHALL require immediate valid_o=0 and, after release with valid_i=4'b1010, a first grant of channel 1.
REQ-035 The bench SHALL toggle ready_i every cycle under full load, and SHALL require no lost or duplicated beats (scoreboard compares count and order per channel).
